// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding, parity modes and data-width decode for the UART transmitter
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  function automatic logic [2:0] last_bit(input logic [1:0] data_bits);
    return 3'd4 + {1'b0, data_bits};
  endfunction
  function automatic logic parity_on(input logic [1:0] mode);
    return mode == PAR_EVEN || mode == PAR_ODD;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with full/empty flags and occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full    = level == (AW+1)'(DEPTH);
  assign empty   = level == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];
  // storage array; no reset needed since level gates every read
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wr_data;
  // pointers wrap naturally on the power-of-two depth; level tracks push minus pop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with per-frame latched configuration
module uart_tx_fifo import uart_pkg::*; #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [1:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  tx_state_t state;
  logic [DIV_W-1:0] baud_cnt, div_l;
  logic [2:0] bit_cnt, bits_l;
  logic [1:0] par_l;
  logic stop2_l, par_acc;
  logic [7:0] shreg, rd_data;
  logic full, empty, pop, bit_end, last_stop, line;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_valid), .pop(pop), .wr_data(tx_data),
    .rd_data(rd_data), .full(full), .empty(empty), .level(fifo_level)
  );
  assign tx_ready  = !full;
  assign bit_end   = baud_cnt == div_l;
  assign last_stop = !stop2_l || bit_cnt[0];
  assign pop       = !empty && (state == IDLE || (state == STOP && bit_end && last_stop));
  // line level implied by the current state; registered below so txd lags state by one clock
  always_comb
    line = state == START ? 1'b0 : state == DATA ? shreg[0] : state == PARITY ? par_acc ^ (par_l == PAR_ODD) : 1'b1;
  // frame sequencer: a pop reloads config and data, otherwise advance one bit per baud period
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      div_l    <= '0;
      bit_cnt  <= '0;
      bits_l   <= '0;
      par_l    <= '0;
      stop2_l  <= 1'b0;
      par_acc  <= 1'b0;
      shreg    <= '0;
      txd      <= 1'b1;
      busy     <= 1'b0;
    end else begin
      txd  <= line;
      busy <= state != IDLE;
      if (pop) begin
        state    <= START;
        baud_cnt <= '0;
        bit_cnt  <= '0;
        shreg    <= rd_data;
        par_acc  <= 1'b0;
        div_l    <= cfg_div;
        bits_l   <= last_bit(cfg_data_bits);
        par_l    <= cfg_parity;
        stop2_l  <= cfg_stop2;
      end else if (state != IDLE) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
        if (bit_end)
          case (state)
            START: state <= DATA;
            DATA: begin
              shreg   <= shreg >> 1;
              par_acc <= par_acc ^ shreg[0];
              bit_cnt <= bit_cnt == bits_l ? '0 : bit_cnt + 1'b1;
              if (bit_cnt == bits_l) state <= parity_on(par_l) ? PARITY : STOP;
            end
            PARITY: state <= STOP;
            STOP: begin
              bit_cnt <= bit_cnt + 1'b1;
              if (last_stop) state <= IDLE;
            end
            default: state <= IDLE;
          endcase
      end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: table-driven and scoreboard checks of the buffered UART transmitter
module tb_uart_tx_fifo;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [7:0] tx_data = '0;
  logic tx_valid = 1'b0;
  logic tx_ready;
  logic [15:0] cfg_div = '0;
  logic [1:0] cfg_data_bits = 2'b11;
  logic [1:0] cfg_parity = 2'b00;
  logic cfg_stop2 = 1'b0;
  logic txd, busy;
  logic [2:0] fifo_level;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cfg_div(cfg_div), .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .txd(txd), .busy(busy), .fifo_level(fifo_level)
  );

  typedef struct {logic [11:0] bits; int nbits; int period;} frame_t;
  typedef struct {logic [7:0] data; logic [15:0] div; logic [1:0] nb; logic [1:0] par; logic stop2; logic [11:0] bits; int nbits;} vec_t;

  frame_t exp_q[$];
  frame_t cur;
  logic mon_on = 1'b0;
  logic prev_txd = 1'b1;
  int mon_cyc = 0;
  int frames_done = 0;
  int idle_run = 0;
  int gapped = 0;
  int busy_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic frame_t mk(input logic [7:0] d);
    frame_t f;
    int k;
    logic p;
    f.bits = '1;
    f.bits[0] = 1'b0;
    k = 1;
    p = 1'b0;
    for (int i = 0; i < 5 + int'(cfg_data_bits); i++) begin
      f.bits[k] = d[i];
      p ^= d[i];
      k++;
    end
    if (cfg_parity == 2'b01) begin f.bits[k] = p; k++; end
    else if (cfg_parity == 2'b10) begin f.bits[k] = ~p; k++; end
    k += cfg_stop2 ? 2 : 1;
    f.nbits = k;
    f.period = int'(cfg_div) + 1;
    return f;
  endfunction

  // line monitor: pops an expected frame at each start edge and checks every cycle of it
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      mon_on = 1'b0;
      prev_txd = 1'b1;
      idle_run = 0;
    end else begin
      if (busy === 1'b1) busy_cnt++;
      if (!mon_on) begin
        if (txd !== 1'b1 && prev_txd === 1'b1) begin
          chk("start_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            mon_on = 1'b1;
            mon_cyc = 0;
            if (idle_run != 0) gapped++;
          end
        end else if (txd === 1'b1) begin
          idle_run++;
          chk("idle_busy", busy, 0);
        end
      end
      if (mon_on) begin
        chk("txd_bit", txd, cur.bits[mon_cyc / cur.period]);
        chk("frame_busy", busy, 1);
        mon_cyc++;
        if (mon_cyc == cur.nbits * cur.period) begin
          mon_on = 1'b0;
          frames_done++;
          idle_run = 0;
        end
      end
      prev_txd = txd;
    end
  end

  task automatic send(input logic [7:0] d, input frame_t f);
    int t = 0;
    tx_data = d;
    tx_valid = 1'b1;
    while (!tx_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", t < 2000, 1);
    exp_q.push_back(f);
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || mon_on) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_drain"}, t < 5000, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic apply_vec(input vec_t v);
    frame_t f;
    cfg_div = v.div;
    cfg_data_bits = v.nb;
    cfg_parity = v.par;
    cfg_stop2 = v.stop2;
    busy_cnt = 0;
    f.bits = v.bits;
    f.nbits = v.nbits;
    f.period = int'(v.div) + 1;
    send(v.data, f);
    tx_valid = 1'b0;
    chk("latency_e0", txd, 1);
    @(negedge clk);
    chk("latency_e1", txd, 1);
    @(negedge clk);
    chk("latency_e2", txd, 0);
    wait_idle("vec");
    chk("vec_busy_cycles", busy_cnt, v.nbits * (int'(v.div) + 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int nf;
    vecs[0] = '{8'hA5, 16'd3, 2'b11, 2'b00, 1'b0, 12'h34A, 10};
    vecs[1] = '{8'h53, 16'd1, 2'b10, 2'b01, 1'b1, 12'h6A6, 11};
    vecs[2] = '{8'h1F, 16'd2, 2'b00, 2'b10, 1'b0, 12'h0BE, 8};
    vecs[3] = '{8'h00, 16'd0, 2'b11, 2'b10, 1'b1, 12'hE00, 12};
    vecs[4] = '{8'hFF, 16'd0, 2'b01, 2'b11, 1'b0, 12'h0FE, 8};
    vecs[5] = '{8'h3C, 16'd2, 2'b11, 2'b01, 1'b0, 12'h478, 11};
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", tx_ready, 1);
    #2 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) apply_vec(vecs[i]);
    // burst into a depth-4 FIFO: five accepted before back-pressure, no idle gaps
    cfg_div = 16'd0;
    cfg_data_bits = 2'b11;
    cfg_parity = 2'b00;
    cfg_stop2 = 1'b0;
    gapped = 0;
    nf = frames_done;
    for (int i = 0; i < 6; i++) begin
      send(8'(8'h10 + i), mk(8'(8'h10 + i)));
      if (i == 0) chk("burst_level_first", fifo_level, 1);
      if (i == 1) chk("burst_level_pushpop", fifo_level, 1);
      if (i == 4) begin
        chk("burst_full_ready", tx_ready, 0);
        chk("burst_full_level", fifo_level, 4);
      end
    end
    tx_valid = 1'b0;
    wait_idle("burst");
    chk("burst_frames", frames_done - nf, 6);
    chk("burst_gapped", gapped, 1);
    // divisor changed mid-frame affects only the following frame
    cfg_div = 16'd3;
    busy_cnt = 0;
    send(8'h3C, mk(8'h3C));
    tx_valid = 1'b0;
    repeat (10) @(negedge clk);
    cfg_div = 16'd7;
    send(8'hC3, mk(8'hC3));
    tx_valid = 1'b0;
    wait_idle("cfgchg");
    chk("cfgchg_busy_cycles", busy_cnt, 40 + 80);
    // reset in DATA with three words queued
    cfg_div = 16'd3;
    for (int i = 0; i < 4; i++) send(8'(8'hA0 + i), mk(8'(8'hA0 + i)));
    tx_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("prerst_level", fifo_level, 3);
    chk("prerst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_txd", txd, 1);
    chk("midrst_level", fifo_level, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", tx_ready, 1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    nf = frames_done;
    repeat (40) @(negedge clk);
    chk("postrst_frames", frames_done - nf, 0);
    chk("postrst_txd", txd, 1);
    chk("postrst_level", fifo_level, 0);
    apply_vec(vecs[0]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
